negedge_gen: RTL

Programmable falling-edge burst generator: the transmit side of the falling-edge detection path. On a start handshake it drives `sig` through N high/low cycles of programmed width, producing exactly N falling edges, then pulses `done`. It sits upstream of the falling-edge detector and is used to stimulate it with controlled edge trains.

---
 rtl/negedge_gen_pkg.sv | 17 +
 rtl/negedge_det.sv | 22 ++
 rtl/negedge_gen.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/negedge_gen_pkg.sv
// Shared types and default widths for the falling-edge burst generator.
package negedge_gen_pkg;

    // Default width of the edge count and the num_edges field.
    localparam int DEFAULT_CNT_W = 8;
    // Default width of the high_len / low_len phase-length fields.
    localparam int DEFAULT_W_W   = 4;

    // Generator control states. The waveform level follows the state:
    // HIGH drives sig=1 before each fall, LOW drives sig=0 after it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/negedge_det.sv
// Falling-edge detector: one-cycle registered pulse on each 1->0 transition of din.
module negedge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic detection
);

    logic din_q;

    // Remember the previous level and flag a high-to-low step one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            din_q     <= 1'b1;
            detection <= 1'b0;
        end else begin
            din_q     <= din;
            detection <= din_q & ~din;
        end
    end

endmodule

// File: rtl/negedge_gen.sv
// Programmable falling-edge burst generator.
// Handshake (valid/ready): a request transfers on a rising edge where
// start_valid and start_ready are both high; start_ready is high exactly
// when the generator is IDLE, so it never depends on start_valid.
// After acceptance sig runs N cycles of (h high, l low), producing N
// falling edges, then done pulses for one cycle. N=0 gives only a done
// pulse one cycle after the handshake. abort ends a burst early without done.
module negedge_gen
    import negedge_gen_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W,
    parameter int W_W   = DEFAULT_W_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [CNT_W-1:0] num_edges,
    input  logic [W_W-1:0]   high_len,
    input  logic [W_W-1:0]   low_len,
    input  logic             abort,
    output logic             sig,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] edge_cnt,
    output state_t           fsm_state
);

    // A programmed length of 0 behaves as a single cycle.
    function automatic logic [W_W-1:0] phase_len(input logic [W_W-1:0] v);
        return (v == '0) ? W_W'(1) : v;
    endfunction

    state_t           state_q,   state_n;
    logic [W_W-1:0]   cnt_q,     cnt_n;      // cycles left in current phase, minus one
    logic [CNT_W-1:0] edge_n;
    logic [CNT_W-1:0] n_lat_q,   n_lat_n;    // requested edge count
    logic [W_W-1:0]   h_lat_q,   h_lat_n;    // effective high length
    logic [W_W-1:0]   l_lat_q,   l_lat_n;    // effective low length
    logic             sig_n;
    logic             done_n;
    logic             zero_pend_q, zero_pend_n; // N=0 request waiting for its done pulse
    logic             handshake;

    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign fsm_state   = state_q;
    assign handshake   = start_valid & start_ready;

    // State and datapath registers; reset returns every output to its idle value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            edge_cnt    <= '0;
            n_lat_q     <= '0;
            h_lat_q     <= W_W'(1);
            l_lat_q     <= W_W'(1);
            sig         <= 1'b1;
            done        <= 1'b0;
            zero_pend_q <= 1'b0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            edge_cnt    <= edge_n;
            n_lat_q     <= n_lat_n;
            h_lat_q     <= h_lat_n;
            l_lat_q     <= l_lat_n;
            sig         <= sig_n;
            done        <= done_n;
            zero_pend_q <= zero_pend_n;
        end
    end

    // Next-state, phase counting and waveform decisions.
    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        edge_n      = edge_cnt;
        n_lat_n     = n_lat_q;
        h_lat_n     = h_lat_q;
        l_lat_n     = l_lat_q;
        sig_n       = sig;
        done_n      = 1'b0;
        zero_pend_n = 1'b0;

        case (state_q)
            IDLE: begin
                sig_n = 1'b1;
                // An empty burst reports completion one cycle after acceptance.
                if (zero_pend_q) begin
                    done_n = 1'b1;
                end
                // abort is meaningless here; a request in the same cycle still goes through.
                if (handshake) begin
                    n_lat_n = num_edges;
                    h_lat_n = phase_len(high_len);
                    l_lat_n = phase_len(low_len);
                    edge_n  = '0;
                    if (num_edges == '0) begin
                        zero_pend_n = 1'b1;
                    end else begin
                        state_n = HIGH;
                        cnt_n   = phase_len(high_len) - W_W'(1);
                    end
                end
            end

            HIGH: begin
                if (abort) begin
                    state_n = IDLE;
                    sig_n   = 1'b1;
                end else if (cnt_q == '0) begin
                    // End of the high phase: emit the falling edge.
                    state_n = LOW;
                    sig_n   = 1'b0;
                    edge_n  = edge_cnt + CNT_W'(1);
                    cnt_n   = l_lat_q - W_W'(1);
                end else begin
                    cnt_n = cnt_q - W_W'(1);
                end
            end

            LOW: begin
                if (abort) begin
                    state_n = IDLE;
                    sig_n   = 1'b1;
                end else if (cnt_q == '0) begin
                    sig_n = 1'b1;
                    if (edge_cnt == n_lat_q) begin
                        // All requested edges emitted: finish with the final rise.
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = HIGH;
                        cnt_n   = h_lat_q - W_W'(1);
                    end
                end else begin
                    cnt_n = cnt_q - W_W'(1);
                end
            end

            default: begin
                state_n = IDLE;
                sig_n   = 1'b1;
            end
        endcase
    end

endmodule
